// File: rtl/sram_responder_if.sv
// Request/response bus for sram_responder: one request channel, one in-order response channel.
interface sram_responder_if #(
  parameter int BYTES_WIDTH = 4,
  parameter int SIZE        = 1024
) ();
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [BYTES_WIDTH-1:0]     req_byteenable;
  logic [$clog2(SIZE)-1:0]    req_addr;
  logic [BYTES_WIDTH*8-1:0]   req_wdata;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [BYTES_WIDTH*8-1:0]   resp_rdata;
  logic                       resp_is_write;

  modport master (
    output req_valid, req_we, req_byteenable, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_is_write
  );

  modport slave (
    input  req_valid, req_we, req_byteenable, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_is_write
  );
endinterface

// File: rtl/sram_responder.sv
// Single-port SRAM with byte-enable writes, one-cycle registered read and a credited in-order response FIFO.
// Define SRAM_RESPONDER_WRITE_ACK_EN to make every write return an acknowledge response.
module sram_responder #(
  parameter int BYTES_WIDTH = 4,
  parameter int SIZE        = 1024,
  parameter int RESP_DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  sram_responder_if.slave bus
);
  localparam int DW = BYTES_WIDTH * 8;
  localparam int AW = $clog2(SIZE);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic [DW-1:0] mem [SIZE];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] fifo_data [RESP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          inflight_q;
  logic          inflight_d;
  logic          ready_q;
  logic          ready_d;
  logic          accept;
  logic          push;
  logic          pop;
  logic          valid;
  logic [DW-1:0] push_data;
  logic [AW-1:0] addr;

  assign addr = bus.req_addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef SRAM_RESPONDER_WRITE_ACK_EN
  logic fifo_wr [RESP_DEPTH];
  logic inflight_wr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_wr_q <= 1'b0;
    end else begin
      inflight_wr_q <= accept && bus.req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_wr[wr_ptr] <= inflight_wr_q;
    end
  end

  assign push_data         = inflight_wr_q ? '0 : rd_q;
  assign bus.resp_is_write = valid && fifo_wr[rd_ptr];
`else
  assign push_data         = rd_q;
  assign bus.resp_is_write = 1'b0;
`endif

  always_comb begin
    accept = bus.req_valid && ready_q;
    push   = inflight_q;
    valid  = (count != '0);
    pop    = valid && bus.resp_ready;
`ifdef SRAM_RESPONDER_WRITE_ACK_EN
    inflight_d = accept;
`else
    inflight_d = accept && !bus.req_we;
`endif
    count_d = count;
    if (push && !pop) begin
      count_d = count + CW'(1);
    end else if (!push && pop) begin
      count_d = count - CW'(1);
    end
    // Registered form of (fifo_count + inflight) < RESP_DEPTH; lets reset hold it low.
    ready_d = (int'(count_d) + int'(inflight_d)) < RESP_DEPTH;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      inflight_q <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      ready_q    <= ready_d;
      inflight_q <= inflight_d;
      count      <= count_d;
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_data[wr_ptr] <= push_data;
    end
  end

  // Storage is never reset; a write landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst && accept && bus.req_we) begin
      for (int unsigned b = 0; b < BYTES_WIDTH; b++) begin
        if (bus.req_byteenable[b]) begin
          mem[addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
    end
    if (accept && !bus.req_we) begin
      rd_q <= mem[addr];
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid;
  assign bus.resp_rdata = valid ? fifo_data[rd_ptr] : '0;
endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder; follows SRAM_RESPONDER_WRITE_ACK_EN like the design.
module tb_sram_responder;
  localparam int BW = 4;
  localparam int SZ = 1024;
  localparam int RD = 4;
`ifdef SRAM_RESPONDER_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sram_responder_if #(.BYTES_WIDTH(BW), .SIZE(SZ)) bus ();

  sram_responder #(.BYTES_WIDTH(BW), .SIZE(SZ), .RESP_DEPTH(RD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid      = 1'b0;
    bus.req_we         = 1'b0;
    bus.req_byteenable = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
  endtask

  task automatic drive(input bit we, input int addr, input logic [31:0] data, input logic [3:0] be);
    bus.req_valid      = 1'b1;
    bus.req_we         = we;
    bus.req_addr       = 10'(addr);
    bus.req_wdata      = data;
    bus.req_byteenable = be;
  endtask

  // Holds a request until accepted, then returns one cycle later with the bus idle.
  task automatic do_req(input bit we, input int addr, input logic [31:0] data, input logic [3:0] be);
    bit done = 1'b0;
    drive(we, addr, data, be);
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.req_ready) done = 1'b1;
      tick();
    end
    idle();
    if (!done) begin
      total++; bad++;
      $display("FAIL req_accept_timeout addr=%0d got=no accept exp=accept", addr);
    end
  endtask

  task automatic drain();
    bus.resp_ready = 1'b1;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    idle();
    bus.resp_ready = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_is_write} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {bus.req_ready, bus.resp_valid, bus.resp_is_write});
    end
    total++;
    if (bus.resp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=00000000", bus.resp_rdata);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release got=%b exp=10", {bus.req_ready, bus.resp_valid});
    end
  endtask

  task automatic test_write_read();
    bus.resp_ready = 1'b1;
    drive(1'b1, 'h010, 32'hDEADBEEF, 4'b1111);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL wr_accept got=%b exp=1", bus.req_ready);
    end
    tick();
    drive(1'b0, 'h010, 32'h0, 4'b0000);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL rd_accept got=%b exp=1", bus.req_ready);
    end
    tick();
    idle();
    total++;
    if (WACK) begin
      if ({bus.resp_valid, bus.resp_is_write, bus.resp_rdata} !== {2'b11, 32'h0}) begin
        bad++; $display("FAIL wr_ack_cycle2 got=%b/%b/%h exp=1/1/00000000", bus.resp_valid, bus.resp_is_write, bus.resp_rdata);
      end
    end else if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL early_resp_cycle2 got=%b exp=0", bus.resp_valid);
    end
    tick();
    total++;
    if ({bus.resp_valid, bus.resp_is_write, bus.resp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_resp_cycle3 got=%b/%b/%h exp=1/0/deadbeef", bus.resp_valid, bus.resp_is_write, bus.resp_rdata);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL resp_clear_cycle4 got=%b exp=0", bus.resp_valid);
    end
  endtask

  task automatic test_byte_merge();
    bit found = 1'b0;
    bus.resp_ready = 1'b1;
    do_req(1'b1, 5, 32'h11223344, 4'b1111);
    do_req(1'b1, 5, 32'hAABBCCDD, 4'b0101);
    do_req(1'b0, 5, 32'h0, 4'b0000);
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.resp_valid && !bus.resp_is_write) begin
        found = 1'b1;
        total++;
        if (bus.resp_rdata !== 32'h11BB33DD) begin
          bad++; $display("FAIL byte_merge got=%h exp=11bb33dd", bus.resp_rdata);
        end
      end
      tick();
    end
    if (!found) begin
      total++; bad++; $display("FAIL byte_merge_timeout got=none exp=response");
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 10; k++) do_req(1'b1, 100 + k, 32'hB000_0000 + k, 4'b1111);
    drain();
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 100 + acc, 32'h0, 4'b0000);
      if (bus.req_ready) acc++;
      tick();
    end
    total++;
    if (acc != 4) begin
      bad++; $display("FAIL bp_accepts got=%0d exp=4", acc);
    end
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata} !== {2'b01, 32'hB000_0000}) begin
      bad++; $display("FAIL bp_stall got=%b/%b/%h exp=0/1/b0000000", bus.req_ready, bus.resp_valid, bus.resp_rdata);
    end
    tick();
    total++;
    if (bus.resp_rdata !== 32'hB000_0000) begin
      bad++; $display("FAIL bp_stable got=%h exp=b0000000", bus.resp_rdata);
    end
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (acc < 10) begin
        drive(1'b0, 100 + acc, 32'h0, 4'b0000);
        if (bus.req_ready) acc++;
      end else begin
        idle();
      end
      if (bus.resp_valid) begin
        total++;
        if (bus.resp_rdata !== 32'hB000_0000 + got) begin
          bad++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, bus.resp_rdata, 32'hB000_0000 + got);
        end
        got++;
      end
      tick();
    end
    idle();
    total++;
    if (acc != 10 || got != 10) begin
      bad++; $display("FAIL bp_complete got=%0d/%0d exp=10/10", acc, got);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 64; k++) do_req(1'b1, 200 + k, {16'hC0DE, 16'(k)}, 4'b1111);
    drain();
    for (int c = 0; c < 72; c++) begin
      if (c < 64) begin
        drive(1'b0, 200 + acc, 32'h0, 4'b0000);
        if (bus.req_ready) acc++;
      end else begin
        idle();
      end
      if (bus.resp_valid) begin
        total++;
        if (bus.resp_rdata !== {16'hC0DE, 16'(got)}) begin
          bad++; $display("FAIL tp_order idx=%0d got=%h exp=%h", got, bus.resp_rdata, {16'hC0DE, 16'(got)});
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    idle();
    total++;
    if (acc != 64 || got != 64) begin
      bad++; $display("FAIL tp_counts got=%0d/%0d exp=64/64", acc, got);
    end
    total++;
    if (first != 2 || last != 65) begin
      bad++; $display("FAIL tp_no_bubbles got=%0d..%0d exp=2..65", first, last);
    end
  endtask

  task automatic test_reset_midstream();
    bit found = 1'b0;
    bus.resp_ready = 1'b1;
    do_req(1'b1, 300, 32'h0DD0_0001, 4'b1111);
    drain();
    bus.resp_ready = 1'b0;
    repeat (3) do_req(1'b0, 300, 32'h0, 4'b0000);
    repeat (2) tick();
    total++;
    if (bus.resp_valid !== 1'b1) begin
      bad++; $display("FAIL mid_queued got=%b exp=1", bus.resp_valid);
    end
    drive(1'b1, 300, 32'hBAD0_BAD0, 4'b1111);
    rst = 1'b0;
    tick();
    idle();
    rst = 1'b1;
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b00) begin
      bad++; $display("FAIL mid_in_reset got=%b exp=00", {bus.req_ready, bus.resp_valid});
    end
    tick();
    total++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      bad++; $display("FAIL mid_after_release got=%b exp=10", {bus.req_ready, bus.resp_valid});
    end
    bus.resp_ready = 1'b1;
    do_req(1'b0, 300, 32'h0, 4'b0000);
    for (int c = 0; c < 10 && !found; c++) begin
      if (bus.resp_valid) begin
        found = 1'b1;
        total++;
        if ({bus.resp_is_write, bus.resp_rdata} !== {1'b0, 32'h0DD0_0001}) begin
          bad++; $display("FAIL mid_old_data got=%b/%h exp=0/0dd00001", bus.resp_is_write, bus.resp_rdata);
        end
      end
      tick();
    end
    if (!found) begin
      total++; bad++; $display("FAIL mid_timeout got=none exp=response");
    end
    drain();
  endtask

  task automatic test_write_ack();
    logic [31:0] got_d [8];
    bit          got_w [8];
    int          n = 0;
    int          acc = 0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: drive(1'b1, 7, 32'h5A5A_1234, 4'b1111);
        1: drive(1'b0, 7, 32'h0, 4'b0000);
        2: drive(1'b1, 8, 32'h0000_0042, 4'b1111);
        default: idle();
      endcase
      if (c < 3 && bus.req_ready) acc++;
      if (bus.resp_valid && n < 8) begin
        got_d[n] = bus.resp_rdata;
        got_w[n] = bus.resp_is_write;
        n++;
      end
      tick();
    end
    idle();
    total++;
    if (acc != 3) begin
      bad++; $display("FAIL ack_accepts got=%0d exp=3", acc);
    end
    total++;
    if (n != (WACK ? 3 : 1)) begin
      bad++; $display("FAIL ack_count got=%0d exp=%0d", n, WACK ? 3 : 1);
    end else if (WACK) begin
      total++;
      if ({got_w[0], got_d[0], got_w[1], got_d[1], got_w[2], got_d[2]} !==
          {1'b1, 32'h0, 1'b0, 32'h5A5A_1234, 1'b1, 32'h0}) begin
        bad++; $display("FAIL ack_seq got=%b/%h %b/%h %b/%h exp=1/00000000 0/5a5a1234 1/00000000",
                        got_w[0], got_d[0], got_w[1], got_d[1], got_w[2], got_d[2]);
      end
    end else begin
      total++;
      if ({got_w[0], got_d[0]} !== {1'b0, 32'h5A5A_1234}) begin
        bad++; $display("FAIL ack_read_only got=%b/%h exp=0/5a5a1234", got_w[0], got_d[0]);
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_write_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter BYTES_WIDTH, default 4: data width in bytes.
REQ-002 Parameter SIZE, default 1024: storage depth in words.
REQ-003 Parameter RESP_DEPTH, default 4: response FIFO entries; legal range 2..16.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low.
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: request accepted when req_valid and req_ready are both high.
REQ-008 Port req_we, input, 1: 1 = write, 0 = read.
REQ-009 Port req_byteenable, input, BYTES_WIDTH: per-byte write enable; ignored on reads.
REQ-010 Port req_addr, input, $clog2(SIZE): word address.
REQ-011 Port req_wdata, input, BYTES_WIDTH*8: write data.
REQ-012 Port resp_valid, output, 1: response present.
REQ-013 Port resp_ready, input, 1: response consumed when resp_valid and resp_ready are both high.
REQ-014 Port resp_rdata, output, BYTES_WIDTH*8: read data.
REQ-015 Port resp_is_write, output, 1: response is a write acknowledge.

Function
REQ-016 The module SHALL hold SIZE words of storage with a one-cycle registered read and byte-granular writes.
- Storage is inferred inside the module.
- Storage contents are not initialised.
REQ-017 Request acceptance SHALL be gated by a credit rule: req_ready = (fifo_count + inflight) < RESP_DEPTH.
- inflight is 1 when a read or acknowledged write was accepted in the previous cycle, else 0.
- req_ready SHALL depend only on registered state, never on resp_ready or req_valid.
REQ-018 A read accepted in cycle N SHALL push its data into the response FIFO at the end of cycle N+1; resp_valid SHALL be high from cycle N+2.
REQ-019 Writes SHALL update storage at the end of the accept cycle, for enabled bytes only.
REQ-020 Write-first ordering: a read accepted in cycle N+1 to an address written in cycle N SHALL return the new data.
REQ-021 Responses SHALL be returned strictly in request order.
REQ-022 FIFO boundary behaviour:
- Simultaneous push and pop SHALL leave the count unchanged.
- Pop on empty SHALL be impossible because resp_valid is 0.
- Push on full SHALL be impossible because of the credit rule.
- Read and write pointers SHALL wrap modulo RESP_DEPTH.
REQ-023 resp_valid, resp_rdata and resp_is_write SHALL be stable while resp_valid is high and resp_ready is low.
REQ-024 With resp_ready held high and RESP_DEPTH >= 3, the block SHALL sustain one accepted request per cycle.

Reset
REQ-025 While rst is low, the following SHALL be forced on the next clock edge: req_ready=0, resp_valid=0, resp_rdata=0, resp_is_write=0, fifo_count=0, inflight=0, both pointers=0.
REQ-026 The cycle after rst returns high, req_ready SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight and queued responses.
- Storage contents SHALL be retained across reset.
- A write accepted in the cycle reset asserts SHALL be dropped.

Configuration
REQ-028 Macro SRAM_RESPONDER_WRITE_ACK_EN controls write acknowledgement.
- Defined: each write SHALL produce one response with resp_is_write=1 and resp_rdata=0, ordered and credited exactly like a read.
- Undefined: writes SHALL produce no response and consume no credit; resp_is_write SHALL be tied 0.

Verification
REQ-029 Write-then-read: write addr 0x010, data 0xDEADBEEF, byteenable 4'b1111; read addr 0x010 the next cycle -> resp_rdata=0xDEADBEEF at cycle 3 (counting the write accept as cycle 0).
REQ-030 Byte merge: write 0x11223344 with byteenable 4'b1111, then write 0xAABBCCDD with byteenable 4'b0101, to addr 5; read addr 5 -> 0x11BB33DD.
REQ-031 Backpressure: resp_ready=0 with 10 reads issued back-to-back, RESP_DEPTH=4 -> req_ready falls after 4 accepts; releasing resp_ready returns the 4 responses in order, then the remaining 6 reads complete.
REQ-032 Throughput: resp_ready=1 with 64 consecutive reads -> 64 accepts in 64 cycles; responses in order; no bubbles after the first response.
REQ-033 Reset mid-stream: 3 responses queued, rst low for 1 cycle -> resp_valid=0 and req_ready=1 after release; a later read of a previously written address returns the old data.
REQ-034 Write ack (macro defined): interleave write/read/write -> three responses with resp_is_write = 1, 0, 1. Macro undefined -> only the read response appears.
